// File: rtl/pes_wm_plant_if.sv
// Controller <-> washing-machine plant bundle: actuator commands one way, sensor/timer status back.
interface pes_wm_plant_if #(
  parameter int LEVEL_W = 8
);
  logic               door_lock;
  logic               fill_value_on;
  logic               drain_value_on;
  logic               motor_on;
  logic               soap_wash;
  logic               water_wash;
  logic               done;
  logic               filled;
  logic               drained;
  logic               detergent_added;
  logic               cycle_timeout;
  logic               spin_timeout;
  logic [LEVEL_W-1:0] level;
  logic               interlock_fault;

  modport master (
    output door_lock, fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, done,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout, level, interlock_fault
  );

  modport slave (
    input  door_lock, fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, done,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout, level, interlock_fault
  );
endinterface

// File: rtl/pes_wm_plant.sv
// Washing-machine plant model: water level, motor/spin timers, detergent dispenser, sticky interlock fault.
// Optional slow leak while idle is compiled in when WM_PLANT_LEAK_EN is defined.
module pes_wm_plant #(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 8,
  parameter int CNT_W       = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int DET_TICKS   = 20,
  parameter int LEAK_PERIOD = 64
) (
  input  logic            clk,
  input  logic            reset,
  pes_wm_plant_if.slave   wm
);

  typedef enum logic [1:0] {D_IDLE, D_DISPENSE, D_ADDED} disp_e;

  disp_e              disp_q, disp_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, spin_q, spin_d;
  logic               cyc_to_q, cyc_to_d, spin_to_q, spin_to_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               fault_q, fault_d;
  logic [LEVEL_W:0]   fill_sum;
  logic [LEVEL_W-1:0] fill_sat, drain_sat;
  logic               cyc_run, spin_run, disp_start;
  logic [CNT_W-1:0]   dcnt_inc;

  // Arithmetic one bit wider than the level so overflow/underflow can be clamped.
  assign fill_sum  = {1'b0, level_q} + (LEVEL_W+1)'(FILL_RATE);
  assign fill_sat  = (fill_sum >= (LEVEL_W+1)'(FULL_LEVEL)) ? LEVEL_W'(FULL_LEVEL) : fill_sum[LEVEL_W-1:0];
  assign drain_sat = ({1'b0, level_q} < (LEVEL_W+1)'(DRAIN_RATE)) ? '0 : level_q - LEVEL_W'(DRAIN_RATE);

`ifdef WM_PLANT_LEAK_EN
  localparam int LEAK_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  logic [LEAK_W-1:0] leak_q, leak_d;
  logic              leak_run, leak_tick;

  assign leak_run  = !wm.fill_value_on && !wm.drain_value_on && (level_q != '0);
  assign leak_tick = leak_run && (leak_q == LEAK_W'(LEAK_PERIOD-1));
  assign leak_d    = (leak_run && !leak_tick) ? leak_q + LEAK_W'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) leak_q <= '0;
    else       leak_q <= leak_d;
  end
`else
  logic unused_leak_cfg;
  assign unused_leak_cfg = (LEAK_PERIOD > 0);
`endif

  always_comb begin
    level_d = level_q;
    if (wm.fill_value_on && !wm.drain_value_on) begin
      if (wm.door_lock) level_d = fill_sat;
    end else if (wm.drain_value_on && !wm.fill_value_on) begin
      level_d = drain_sat;
    end
`ifdef WM_PLANT_LEAK_EN
    if (leak_tick) level_d = level_q - LEVEL_W'(1);
`endif
  end

  // Timers restart from zero whenever their run condition drops.
  assign cyc_run   = wm.motor_on && wm.door_lock;
  assign spin_run  = wm.drain_value_on && wm.water_wash && wm.door_lock;
  assign cyc_to_d  = cyc_run && (cyc_q == CNT_W'(CYCLE_TICKS-1));
  assign spin_to_d = spin_run && (spin_q == CNT_W'(SPIN_TICKS-1));
  assign cyc_d     = (cyc_run && !cyc_to_d) ? cyc_q + CNT_W'(1) : '0;
  assign spin_d    = (spin_run && !spin_to_d) ? spin_q + CNT_W'(1) : '0;

  assign disp_start = wm.soap_wash && !wm.water_wash && wm.door_lock &&
                      !wm.fill_value_on && !wm.drain_value_on && !wm.motor_on;
  assign dcnt_inc   = dcnt_q + CNT_W'(1);

  always_comb begin
    disp_d = disp_q;
    dcnt_d = dcnt_q;
    case (disp_q)
      D_IDLE: begin
        if (disp_start) begin
          disp_d = D_DISPENSE;
          dcnt_d = '0;
        end
      end
      D_DISPENSE: begin
        if (!wm.door_lock) begin
          disp_d = D_IDLE;
        end else begin
          dcnt_d = dcnt_inc;
          if (dcnt_inc >= CNT_W'(DET_TICKS-1)) disp_d = D_ADDED;
        end
      end
      D_ADDED: begin
        if (!wm.door_lock || wm.done) disp_d = D_IDLE;
      end
      default: disp_d = D_IDLE;
    endcase
  end

  assign fault_d = fault_q ||
                   ((wm.fill_value_on || wm.motor_on) && !wm.door_lock) ||
                   (wm.fill_value_on && wm.drain_value_on);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      cyc_q     <= '0;
      spin_q    <= '0;
      cyc_to_q  <= 1'b0;
      spin_to_q <= 1'b0;
      disp_q    <= D_IDLE;
      dcnt_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      cyc_q     <= cyc_d;
      spin_q    <= spin_d;
      cyc_to_q  <= cyc_to_d;
      spin_to_q <= spin_to_d;
      disp_q    <= disp_d;
      dcnt_q    <= dcnt_d;
      fault_q   <= fault_d;
    end
  end

  assign wm.level           = level_q;
  assign wm.filled          = (level_q == LEVEL_W'(FULL_LEVEL));
  assign wm.drained         = (level_q == '0);
  assign wm.detergent_added = (disp_q == D_ADDED);
  assign wm.cycle_timeout   = cyc_to_q;
  assign wm.spin_timeout    = spin_to_q;
  assign wm.interlock_fault = fault_q;

endmodule

// File: tb/tb_pes_wm_plant.sv
// Closed-loop bench for pes_wm_plant: directed test-plan scenarios, then randomized commands,
// all checked every cycle against a behavioural plant model.
module tb_pes_wm_plant;
  localparam int FULL = 200, FRATE = 4, DRATE = 8;
  localparam int CYC = 1000, SPIN = 500, DET = 20, LEAKP = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pes_wm_plant_if #(.LEVEL_W(8)) wm ();
  pes_wm_plant dut (.clk(clk), .reset(reset), .wm(wm));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: level in plain integers, timers as "clocks since condition started".
  int m_lvl, m_cyc_n, m_spin_n, m_det_n, m_det_st, m_leak_n;
  bit m_cyc_p, m_spin_p, m_fault;

  function automatic int lvl_next(int l, bit f, bit d, bit dl, bit leak);
    if (f && !d) return dl ? ((l + FRATE > FULL) ? FULL : l + FRATE) : l;
    if (d && !f) return (l < DRATE) ? 0 : l - DRATE;
    if (leak) return l - 1;
    return l;
  endfunction

  wire  idle_valves = !wm.fill_value_on && !wm.drain_value_on;
`ifdef WM_PLANT_LEAK_EN
  wire  leak_on   = idle_valves && (m_lvl > 0);
`else
  wire  leak_on   = 1'b0;
`endif
  wire  leak_fire = leak_on && (m_leak_n + 1 == LEAKP);
  wire  cyc_on    = wm.motor_on && wm.door_lock;
  wire  spin_on   = wm.drain_value_on && wm.water_wash && wm.door_lock;
  wire  cyc_fire  = cyc_on && (m_cyc_n + 1 == CYC);
  wire  spin_fire = spin_on && (m_spin_n + 1 == SPIN);
  wire  det_go    = wm.soap_wash && !wm.water_wash && wm.door_lock && idle_valves && !wm.motor_on;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lvl <= 0; m_cyc_n <= 0; m_spin_n <= 0; m_det_n <= 0; m_det_st <= 0; m_leak_n <= 0;
      m_cyc_p <= 1'b0; m_spin_p <= 1'b0; m_fault <= 1'b0;
    end else begin
      m_lvl    <= lvl_next(m_lvl, wm.fill_value_on, wm.drain_value_on, wm.door_lock, leak_fire);
      m_leak_n <= (leak_on && !leak_fire) ? m_leak_n + 1 : 0;
      m_cyc_n  <= (cyc_on && !cyc_fire) ? m_cyc_n + 1 : 0;
      m_spin_n <= (spin_on && !spin_fire) ? m_spin_n + 1 : 0;
      m_cyc_p  <= cyc_fire;
      m_spin_p <= spin_fire;
      m_fault  <= m_fault || ((wm.fill_value_on || wm.motor_on) && !wm.door_lock) ||
                  (wm.fill_value_on && wm.drain_value_on);
      // m_det_n = clocks spent dispensing, counting the clock that started it
      if (m_det_st == 0) begin
        if (det_go) begin m_det_st <= 1; m_det_n <= 1; end
      end else if (m_det_st == 1) begin
        if (!wm.door_lock) m_det_st <= 0;
        else if (m_det_n + 1 == DET) m_det_st <= 2;
        else m_det_n <= m_det_n + 1;
      end else if (!wm.door_lock || wm.done) begin
        m_det_st <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("level", int'(wm.level), m_lvl);
    chk("filled", int'(wm.filled), int'(m_lvl == FULL));
    chk("drained", int'(wm.drained), int'(m_lvl == 0));
    chk("detergent_added", int'(wm.detergent_added), int'(m_det_st == 2));
    chk("cycle_timeout", int'(wm.cycle_timeout), int'(m_cyc_p));
    chk("spin_timeout", int'(wm.spin_timeout), int'(m_spin_p));
    chk("interlock_fault", int'(wm.interlock_fault), int'(m_fault));
  end

  task automatic drive(input bit dl, input bit f, input bit d, input bit mo,
                       input bit s, input bit w, input bit dn);
    wm.door_lock = dl; wm.fill_value_on = f; wm.drain_value_on = d; wm.motor_on = mo;
    wm.soap_wash = s; wm.water_wash = w; wm.done = dn;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int k, pulses, first_p, second_p, both, lvl_keep;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    edges(2);
    chk("rst_level", int'(wm.level), 0);
    chk("rst_drained", int'(wm.drained), 1);
    chk("rst_filled", int'(wm.filled), 0);
    chk("rst_fault", int'(wm.interlock_fault), 0);
    chk("rst_det", int'(wm.detergent_added), 0);
    reset = 1'b0;

    // Fill: 4 per clock, full after 50 clocks, then saturates.
    drive(1, 1, 0, 0, 0, 0, 0);
    edges(49);
    chk("fill49_level", int'(wm.level), 196);
    chk("fill49_filled", int'(wm.filled), 0);
    edges(1);
    chk("fill50_level", int'(wm.level), 200);
    chk("fill50_filled", int'(wm.filled), 1);
    edges(5);
    chk("fill_sat_level", int'(wm.level), 200);

    // Drain: 8 per clock, empty after 25 clocks, never below zero.
    drive(1, 0, 1, 0, 0, 0, 0);
    edges(24);
    chk("drain24_drained", int'(wm.drained), 0);
    edges(1);
    chk("drain25_drained", int'(wm.drained), 1);
    edges(3);
    chk("drain_floor", int'(wm.level), 0);

    // Motor held 2000 clocks: pulses exactly at clocks 1000 and 2000.
    drive(1, 0, 0, 1, 0, 0, 0);
    pulses = 0; first_p = 0; second_p = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (wm.cycle_timeout) begin
        pulses++;
        if (pulses == 1) first_p = i; else if (pulses == 2) second_p = i;
      end
    end
    chk("cyc_pulses", pulses, 2);
    chk("cyc_first", first_p, 1000);
    chk("cyc_second", second_p, 2000);
    edges(600);
    drive(1, 0, 0, 0, 0, 0, 0);
    edges(1);
    drive(1, 0, 0, 1, 0, 0, 0);
    k = 0;
    for (int i = 1; i <= 1100 && k == 0; i++) begin
      @(negedge clk);
      if (wm.cycle_timeout) k = i;
    end
    chk("cyc_restart", k, 1000);

    // Dispenser: added 20 clocks after the soap request.
    drive(1, 0, 0, 0, 1, 0, 0);
    k = 0;
    for (int i = 1; i <= 100 && k == 0; i++) begin
      @(negedge clk);
      if (wm.detergent_added) k = i;
    end
    chk("det_latency", k, 20);

    // Rinse with motor and spin together: spin at 500 and 1000, both pulses coincide at 1000.
    drive(1, 0, 1, 1, 0, 1, 0);
    pulses = 0; both = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (wm.spin_timeout) pulses++;
      if (wm.spin_timeout && wm.cycle_timeout) both = i;
    end
    chk("spin_pulses", pulses, 2);
    chk("both_pulses_at", both, 1000);
    chk("det_through_rinse", int'(wm.detergent_added), 1);
    drive(1, 0, 0, 0, 0, 1, 1);
    edges(1);
    chk("det_after_done", int'(wm.detergent_added), 0);

    // Fill to 100 then idle 640 clocks (leak drops it by 10 when compiled in).
    drive(1, 1, 0, 0, 0, 0, 0);
    edges(25);
    chk("fill_to_100", int'(wm.level), 100);
    drive(1, 0, 0, 0, 0, 0, 0);
    edges(640);
`ifdef WM_PLANT_LEAK_EN
    chk("leak_640", int'(wm.level), 90);
`else
    chk("leak_640", int'(wm.level), 100);
`endif

    // Fill with door unlocked: level frozen, fault set and held.
    lvl_keep = int'(wm.level);
    drive(0, 1, 0, 0, 0, 0, 0);
    edges(1);
    chk("unlocked_fault", int'(wm.interlock_fault), 1);
    chk("unlocked_level", int'(wm.level), lvl_keep);
    drive(1, 0, 0, 0, 0, 0, 0);
    edges(3);
    chk("fault_sticky", int'(wm.interlock_fault), 1);

    // Reset mid-fill clears asynchronously, before the next clock edge.
    drive(1, 1, 0, 0, 0, 0, 0);
    edges(3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_level", int'(wm.level), 0);
    chk("async_rst_fault", int'(wm.interlock_fault), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized command segments, checked by the per-cycle model compare.
    for (int s = 0; s < 150; s++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0);
      edges($urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
